alu_multicycle: RTL and testbench



---
 rtl/alu_multicycle.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: single-cycle add/sub/logic, iterative shift and unsigned multiply
// behind a start/ready/done handshake. Results and carry are held in registers.
module alu_multicycle #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [1:0]       opcode_modifier,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] d_high,
  output logic             carry,
  output logic             a_is_zero
);

  // Counter must hold WIDTH (multiply iterations), one bit more than a shift amount.
  localparam int unsigned CNT_W  = SHAMT_W + 1;
  localparam int unsigned ADD_W  = WIDTH + 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SHIFT = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_MUL   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic               w_ready;
  logic               w_accept;
  logic               w_shift_step;
  logic               w_mul_step;
  logic               w_last;
  logic [SHAMT_W-1:0] w_shamt;

  logic [WIDTH-1:0]   w_b_eff;
  logic               w_cin;
  logic [ADD_W-1:0]   w_add;

  logic [WIDTH-1:0]   w_sh_next;
  logic               w_sh_out;
  logic [ADD_W-1:0]   w_mul_sum;
  logic [PROD_W-1:0]  w_prod_next;

  logic               r_done;
  logic [WIDTH-1:0]   r_d;
  logic [WIDTH-1:0]   r_dh;
  logic               r_carry;
  logic [1:0]         r_mod;
  logic [WIDTH-1:0]   r_sh;
  logic [WIDTH-1:0]   r_mc;
  logic [PROD_W-1:0]  r_prod;
  logic [CNT_W-1:0]   r_cnt;

  assign w_shamt = b[SHAMT_W-1:0];
  assign w_last  = (r_cnt == CNT_W'(1));

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: only non-zero shifts and multiplies leave IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((opcode == OP_SHIFT) && (w_shamt != '0)) begin
            w_state_next = S_SHIFT;
          end else if (opcode == OP_MUL) begin
            w_state_next = S_MUL;
          end
        end
      end
      S_SHIFT, S_MUL: begin
        if (w_last) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State decode: handshake and per-cycle datapath enables.
  always_comb begin
    w_ready      = 1'b0;
    w_shift_step = 1'b0;
    w_mul_step   = 1'b0;
    case (r_state)
      S_IDLE:  w_ready      = 1'b1;
      S_SHIFT: w_shift_step = 1'b1;
      S_MUL:   w_mul_step   = 1'b1;
      default: w_ready      = 1'b0;
    endcase
    w_accept = w_ready & start;
  end

  // Adder: subtract inverts B; carry-chaining uses the carry present at accept.
  always_comb begin
    w_b_eff = opcode_modifier[0] ? ~b : b;
    w_cin   = opcode_modifier[1] ? r_carry : opcode_modifier[0];
    w_add   = {1'b0, a} + {1'b0, w_b_eff} + ADD_W'(w_cin);
  end

  // One-bit shift step; the bit leaving the word becomes the candidate carry.
  always_comb begin
    if (r_mod[0]) begin
      w_sh_next = {r_sh[WIDTH-2:0], 1'b0};
      w_sh_out  = r_sh[WIDTH-1];
    end else begin
      w_sh_next = {r_mod[1] & r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
      w_sh_out  = r_sh[0];
    end
  end

  // Shift-add multiply step: conditionally add multiplicand to the high half, then shift right.
  always_comb begin
    w_mul_sum   = {1'b0, r_prod[PROD_W-1:WIDTH]} +
                  (r_prod[0] ? {1'b0, r_mc} : ADD_W'(0));
    w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};
  end

  // Datapath: results and carry change only on the edge that raises done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done  <= 1'b0;
      r_d     <= '0;
      r_dh    <= '0;
      r_carry <= 1'b0;
      r_mod   <= '0;
      r_sh    <= '0;
      r_mc    <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_mod  <= opcode_modifier;
        r_sh   <= a;
        r_mc   <= a;
        r_prod <= {{WIDTH{1'b0}}, b};
        r_cnt  <= (opcode == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(w_shamt);
        case (opcode)
          OP_ADD: begin
            {r_carry, r_d} <= w_add;
            r_dh           <= '0;
            r_done         <= 1'b1;
          end
          OP_AND: begin
            r_d    <= a & b;
            r_dh   <= '0;
            r_done <= 1'b1;
          end
          OP_OR: begin
            r_d    <= a | b;
            r_dh   <= '0;
            r_done <= 1'b1;
          end
          OP_XOR: begin
            r_d    <= a ^ b;
            r_dh   <= '0;
            r_done <= 1'b1;
          end
          OP_SHIFT: begin
            if (w_shamt == '0) begin
              r_d    <= a;
              r_dh   <= '0;
              r_done <= 1'b1;
            end
          end
          OP_MUL: begin
            r_done <= 1'b0;
          end
          default: begin
            r_done <= 1'b1;
          end
        endcase
      end
      if (w_shift_step) begin
        r_sh  <= w_sh_next;
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_d     <= w_sh_next;
          r_dh    <= '0;
          r_carry <= w_sh_out;
          r_done  <= 1'b1;
        end
      end
      if (w_mul_step) begin
        r_prod <= w_prod_next;
        r_cnt  <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_d     <= w_prod_next[WIDTH-1:0];
          r_dh    <= w_prod_next[PROD_W-1:WIDTH];
          r_carry <= |w_prod_next[PROD_W-1:WIDTH];
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign ready     = w_ready;
  assign done      = r_done;
  assign d         = r_d;
  assign d_high    = r_dh;
  assign carry     = r_carry;
  assign a_is_zero = (a == '0);

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=16).
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  opcode;
  logic [1:0]  opcode_modifier;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        done;
  logic [15:0] d;
  logic [15:0] d_high;
  logic        carry;
  logic        a_is_zero;

  alu_multicycle #(.WIDTH(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .opcode          (opcode),
    .opcode_modifier (opcode_modifier),
    .a               (a),
    .b               (b),
    .ready           (ready),
    .done            (done),
    .d               (d),
    .d_high          (d_high),
    .carry           (carry),
    .a_is_zero       (a_is_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [15:0] dh;
    logic        c;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [15:0] m_d   = '0;
  logic [15:0] m_dh  = '0;
  logic        m_c   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive a request and push the model's expected completion onto the scoreboard.
  task automatic drive(input logic [2:0] op, input logic [1:0] m,
                       input logic [15:0] av, input logic [15:0] bv);
    exp_t        e;
    logic [16:0] s;
    logic [31:0] p;
    int          n;
    int          lat;
    opcode          = op;
    opcode_modifier = m;
    a               = av;
    b               = bv;
    start           = 1'b1;
    lat             = 1;
    case (op)
      3'd0: begin
        s    = {1'b0, av} + {1'b0, (m[0] ? ~bv : bv)} + 17'(m[1] ? m_c : m[0]);
        m_d  = s[15:0];
        m_c  = s[16];
        m_dh = '0;
      end
      3'd1: begin
        n    = int'(bv[3:0]);
        m_dh = '0;
        if (n == 0) begin
          m_d = av;
        end else begin
          lat = n + 1;
          if (m[0]) begin
            m_c = av[16-n];
            m_d = av << n;
          end else begin
            m_c = av[n-1];
            m_d = m[1] ? 16'($signed(av) >>> n) : (av >> n);
          end
        end
      end
      3'd2: begin m_d = av & bv; m_dh = '0; end
      3'd3: begin m_d = av | bv; m_dh = '0; end
      3'd4: begin m_d = av ^ bv; m_dh = '0; end
      3'd5: begin
        p    = 32'(av) * 32'(bv);
        m_d  = p[15:0];
        m_dh = p[31:16];
        m_c  = (p[31:16] != 16'h0);
        lat  = 17;
      end
      default: ;
    endcase
    e.d   = m_d;
    e.dh  = m_dh;
    e.c   = m_c;
    e.due = cyc + lat;
    q.push_back(e);
  endtask

  // Compare every completion against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (q.size() == 0) begin
        check("done_unexpected", 32'(done), 32'(0));
      end else begin
        e = q.pop_front();
        check("d", 32'(d), 32'(e.d));
        check("d_high", 32'(d_high), 32'(e.dh));
        check("carry", 32'(carry), 32'(e.c));
        check("done_cycle", 32'(cyc), 32'(e.due));
        check("ready_on_done", 32'(ready), 32'(1));
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("pending_timeout", 32'(q.size()), 32'(0));
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] m,
                       input logic [15:0] av, input logic [15:0] bv);
    @(negedge clk);
    drive(op, m, av, bv);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset           = 1'b1;
    start           = 1'b0;
    opcode          = '0;
    opcode_modifier = '0;
    a               = '0;
    b               = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'(1));
    check("rst_done", 32'(done), 32'(0));
    check("rst_d", 32'(d), 32'(0));
    check("rst_d_high", 32'(d_high), 32'(0));
    check("rst_carry", 32'(carry), 32'(0));
    reset = 1'b0;

    a = 16'h0000; #1 check("a_is_zero_0", 32'(a_is_zero), 32'(1));
    a = 16'h0100; #1 check("a_is_zero_1", 32'(a_is_zero), 32'(0));

    // Add with carry-out, then add-with-carry consuming it.
    issue(3'd0, 2'b00, 16'hFFFF, 16'h0001);
    check("add_ovf_d", 32'(d), 32'h0000);
    check("add_ovf_c", 32'(carry), 32'(1));
    issue(3'd0, 2'b10, 16'h0000, 16'h0000);
    check("adc_d", 32'(d), 32'h0001);
    check("adc_c", 32'(carry), 32'(0));

    // Subtract: carry=1 means no borrow.
    issue(3'd0, 2'b01, 16'h0005, 16'h0007);
    check("sub_borrow_d", 32'(d), 32'hFFFE);
    check("sub_borrow_c", 32'(carry), 32'(0));
    issue(3'd0, 2'b01, 16'h0007, 16'h0005);
    check("sub_d", 32'(d), 32'h0002);
    check("sub_c", 32'(carry), 32'(1));

    // Arithmetic right shift by 3: busy for three cycles.
    @(negedge clk);
    drive(3'd1, 2'b10, 16'h8001, 16'h0003);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("shift_busy_ready", 32'(ready), 32'(0));
    end
    wait_idle();
    check("asr3_d", 32'(d), 32'hF000);
    check("asr3_c", 32'(carry), 32'(0));

    issue(3'd1, 2'b01, 16'h8001, 16'h0001);
    check("shl1_d", 32'(d), 32'h0002);
    check("shl1_c", 32'(carry), 32'(1));
    issue(3'd1, 2'b00, 16'h1234, 16'h0000);
    check("shift0_d", 32'(d), 32'h1234);
    check("shift0_c", 32'(carry), 32'(1));

    // Multiply with stray start pulses while busy.
    @(negedge clk);
    drive(3'd5, 2'b00, 16'hFFFF, 16'hFFFF);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("mul_busy_ready", 32'(ready), 32'(0));
      start  = (k == 3 || k == 9);
      opcode = 3'd0;
      a      = 16'h0001;
      b      = 16'h0001;
    end
    start = 1'b0;
    wait_idle();
    check("mul_d", 32'(d), 32'h0001);
    check("mul_dh", 32'(d_high), 32'hFFFE);
    check("mul_c", 32'(carry), 32'(1));

    // Reset in cycle 5 of a multiply aborts it.
    @(negedge clk);
    drive(3'd5, 2'b00, 16'h1234, 16'h5678);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    m_d   = '0;
    m_dh  = '0;
    m_c   = 1'b0;
    check("abort_ready", 32'(ready), 32'(1));
    check("abort_done", 32'(done), 32'(0));
    check("abort_d", 32'(d), 32'(0));
    check("abort_dh", 32'(d_high), 32'(0));
    check("abort_c", 32'(carry), 32'(0));
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) n++;
    end
    check("abort_no_done", 32'(n), 32'(0));

    // Back-to-back XOR with start held high; carry set beforehand.
    issue(3'd0, 2'b00, 16'hFFFF, 16'h0001);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(3'd4, 2'b00, 16'h00FF, 16'h0F0F);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    check("xor_d", 32'(d), 32'h0FF0);
    check("xor_c", 32'(carry), 32'(1));

    // Random mix including reserved opcodes.
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            16'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
